fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined LC-3b datapath, directly upstream of the decode-stage control ROM. Owns the PC and issues 16-bit instruction reads over the read/resp memory handshake. Presents a registered IF/ID bundle (IR, PC, valid) whose opcode and imm-select fields drive the control ROM inputs. Supports stall from decode and redirect (taken branch/jump) from later stages, and holds one fetched word when decode stalls.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_read  out  1  instruction read request
- imem_address  out  16  byte address of request (= pc)
- imem_rdata  in  16  instruction word, valid when imem_resp=1
- imem_resp  in  1  one-cycle read completion
- stall  in  1  decode cannot accept the current IF/ID bundle
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  16  new fetch address; bit 0 ignored (treated as 0)
- if_valid  out  1  IF/ID bundle holds a live instruction
- if_ir  out  16  fetched instruction
- if_pc  out  16  address of if_ir
- if_opcode  out  4 (lc3b_opcode)  if_ir[15:12], combinational, feeds control ROM opcode
- if_imm_check  out  1  if_ir[5], combinational, feeds control ROM imm_check

## Operation
- Registers: pc, tgt (pending redirect target), buf (held word), IF/ID (if_valid, if_ir, if_pc), state ∈ {FETCH, SQUASH, HOLD}.
- accept = !if_valid || !stall. When if_valid && !stall and nothing new loads, if_valid ← 0.
- imem_read = 1 in FETCH and SQUASH, 0 in HOLD and whenever reset=1. imem_address = pc in all states.
- pc increment is pc+2 modulo 2^16 (0xFFFE → 0x0000).
- FETCH:
  - redirect: if_valid ← 0. If imem_resp the same cycle, discard rdata, pc ← redirect_pc, stay FETCH. Otherwise tgt ← redirect_pc, go SQUASH.
  - imem_resp && accept: if_ir ← imem_rdata, if_pc ← pc, if_valid ← 1, pc ← pc+2.
  - imem_resp && !accept: buf ← imem_rdata, go HOLD; pc unchanged.
- SQUASH: keeps the outstanding read alive with an unchanged address; the handshake is never aborted. A new redirect overwrites tgt. On imem_resp, discard data, pc ← (redirect ? redirect_pc : tgt), go FETCH. if_valid stays 0.
- HOLD:
  - redirect: drop buf, if_valid ← 0, pc ← redirect_pc, go FETCH.
  - else if !stall: if_ir ← buf, if_pc ← pc, if_valid ← 1, pc ← pc+2, go FETCH.
- Priority: reset > redirect > resp/stall handling. Redirect with stall flushes, because redirect wins.
- No instruction is ever duplicated or skipped except by redirect flush.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, if_valid=0, if_ir=0, if_pc=0, tgt=0, buf=0; imem_read=0 during reset.
- First request occurs in the first cycle after reset deasserts, with imem_address=RESET_PC.
- Fetch latency: resp in cycle k gives if_valid=1 from cycle k+1.
- Back-to-back: with resp every cycle and no stall, one instruction per cycle. The next request address (pc+2) appears in cycle k+1.
- Redirect latency: if_valid=0 in the cycle after redirect. The first request to the target goes out in the cycle after redirect if resp coincided with the redirect, or otherwise in the cycle after the outstanding resp.
- HOLD release: stall falls in cycle j gives the buffered word in IF/ID at j+1 and the next request in cycle j+1.
- Reset mid-transaction abandons any outstanding read; the memory model must accept the dropped request.

## Test plan
- Reset, resp 2 cycles after each request, no stall: addresses 0x0000, 0x0002, 0x0004 are issued. if_ir/if_pc match the memory words, and if_opcode equals if_ir[15:12].
- Resp every cycle, stall held 3 cycles while if_valid=1: one word goes to HOLD with imem_read=0, IF/ID is unchanged. After stall falls, the words emerge in order with no gap or duplicate.
- Redirect to 0x0040 while a read to 0x0008 is outstanding (resp 2 cycles later): data for 0x0008 is discarded, if_valid=0, and the next request is 0x0040.
- Redirect coinciding with resp, and a second redirect (0x0080) during SQUASH: fetch resumes at the latest target, and no discarded word reaches IF/ID.
- Redirect during HOLD with stall=1: buf is dropped, if_valid=0 next cycle, and fetch restarts at redirect_pc. Redirect_pc 0x0031 fetches 0x0030.
- PC wrap: redirect to 0xFFFE, then continuous fetch: the next address is 0x0000. Reset asserted mid-read: imem_read=0 and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, runs the imem read/resp handshake,
// and presents a registered IF/ID bundle to the decode-stage control ROM.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [3:0]  if_opcode,
  output logic        if_imm_check
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] tgt;
  logic [15:0] hold_buf;
  logic        accept;
  logic [15:0] redir_addr;

  assign accept       = !if_valid || !stall;
  assign redir_addr   = {redirect_pc[15:1], 1'b0};
  assign imem_read    = !reset && (state != HOLD);
  assign imem_address = pc;
  assign if_opcode    = if_ir[15:12];
  assign if_imm_check = if_ir[5];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      tgt      <= 16'h0000;
      hold_buf <= 16'h0000;
      if_valid <= 1'b0;
      if_ir    <= 16'h0000;
      if_pc    <= 16'h0000;
    end else begin
      // Decode consumed the bundle; a load below overrides this drain.
      if (if_valid && !stall) if_valid <= 1'b0;

      case (state)
        FETCH: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if (imem_resp) begin
              pc <= redir_addr;
            end else begin
              tgt   <= redir_addr;
              state <= SQUASH;
            end
          end else if (imem_resp) begin
            if (accept) begin
              if_ir    <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + 16'd2;
            end else begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end
          end
        end

        // The stale read stays on the bus until it completes; only then retarget.
        SQUASH: begin
          if_valid <= 1'b0;
          if (imem_resp) begin
            pc    <= redirect ? redir_addr : tgt;
            state <= FETCH;
          end else if (redirect) begin
            tgt <= redir_addr;
          end
        end

        HOLD: begin
          if (redirect) begin
            if_valid <= 1'b0;
            pc       <= redir_addr;
            state    <= FETCH;
          end else if (!stall) begin
            if_ir    <= hold_buf;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 16'd2;
            state    <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory that answers with an address-derived
// word, random stall/redirect/reset traffic, and a queue-based reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_ir;
  logic [15:0] if_pc;
  logic [3:0]  if_opcode;
  logic        if_imm_check;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [15:0] RESET_PC = 16'h0000;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc),
    .if_opcode(if_opcode), .if_imm_check(if_imm_check)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'd40503;
    return t ^ 16'h3C5A;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch pointer, words parked for decode, and a pending
  // "throw away the in-flight read, then go to m_tgt" obligation.
  logic [15:0] m_pc, m_tgt, m_ir, m_ifpc;
  logic        m_valid, m_discard;
  logic [15:0] parked[$];

  task automatic model_reset();
    m_pc = RESET_PC; m_tgt = 16'h0; m_ir = 16'h0; m_ifpc = 16'h0;
    m_valid = 1'b0; m_discard = 1'b0;
    parked.delete();
  endtask

  task automatic deliver(input logic [15:0] w, input logic [15:0] a);
    m_ir = w; m_ifpc = a; m_valid = 1'b1; m_pc = a + 16'd2;
  endtask

  task automatic model_step();
    logic [15:0] ra;
    bit taken_by_decode;
    ra = {redirect_pc[15:1], 1'b0};
    taken_by_decode = m_valid && !stall;
    if (reset) begin
      model_reset();
    end else if (redirect) begin
      m_valid = 1'b0;
      if (parked.size() != 0) begin
        parked.delete();
        m_pc = ra;
      end else if (imem_resp) begin
        m_pc = ra;
        m_discard = 1'b0;
      end else begin
        m_discard = 1'b1;
        m_tgt = ra;
      end
    end else if (parked.size() != 0) begin
      if (!stall) deliver(parked.pop_front(), m_pc);
    end else if (m_discard) begin
      if (imem_resp) begin
        m_pc = m_tgt;
        m_discard = 1'b0;
      end
    end else if (imem_resp && (!m_valid || !stall)) begin
      deliver(imem_rdata, m_pc);
    end else if (imem_resp) begin
      parked.push_back(imem_rdata);
    end else if (taken_by_decode) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick_target();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0: return 16'hFFFE;
      1: return 16'hFFFC;
      2: return 16'h0031;
      3: return 16'h0040;
      4: return 16'h0080;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int stall_pct;
    model_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_resp = 1'b0; imem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      // Drive control inputs; keep reset for the first cycle, then occasionally.
      stall_pct   = ((cyc / 200) % 2 == 0) ? 20 : 60;
      reset       = (cyc == 0) || ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 99) < stall_pct);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = pick_target();
      #1;
      imem_resp  = imem_read && ($urandom_range(0, 99) < 55);
      imem_rdata = imem_resp ? mem_word(imem_address) : 16'($urandom);

      @(negedge clk);
      check("imem_read",    {15'b0, imem_read}, {15'b0, (!reset && parked.size() == 0)});
      check("imem_address", imem_address, m_pc);
      check("if_valid",     {15'b0, if_valid}, {15'b0, m_valid});
      check("if_ir",        if_ir, m_ir);
      check("if_pc",        if_pc, m_ifpc);
      check("if_opcode",    {12'b0, if_opcode}, {12'b0, m_ir[15:12]});
      check("if_imm_check", {15'b0, if_imm_check}, {15'b0, m_ir[5]});
      if (if_valid) check("if_ir_vs_mem", if_ir, mem_word(if_pc));

      model_step();
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
